keyword_search_ctrl: RTL

Control and configuration block for the four-lane parallel keyword matcher. It owns the keyword table: a shadow copy written by software and an active copy driven onto the matcher's keyword inputs. It tracks packet boundaries on the text stream so that a table commit never lands mid-packet. It also turns the matcher's level match/no-match outputs into a ready/valid verdict stream, returns the ack, and keeps saturating verdict counters.

---
 rtl/keyword_search_ctrl_pkg.sv | 30 +++
 rtl/keyword_search_ctrl_keyword_table.sv | 70 +++++++
 rtl/keyword_search_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/keyword_search_ctrl_pkg.sv
// Shared constants, configuration address layout and verdict FSM encoding
// for the keyword search control block.
package keyword_search_ctrl_pkg;

  localparam int NUM_KW       = 4;
  localparam int KW_W         = 128;
  localparam int CNT_W        = 32;
  localparam int WORD_W       = 32;
  localparam int ADDR_W       = 4;
  localparam int ADDR_KW_HI   = 3;
  localparam int ADDR_KW_LO   = 2;
  localparam int ADDR_WORD_HI = 1;
  localparam int ADDR_WORD_LO = 0;

  typedef enum logic [1:0] {
    V_IDLE  = 2'd0,
    V_HOLD  = 2'd1,
    V_ACK   = 2'd2,
    V_DRAIN = 2'd3
  } vstate_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/keyword_search_ctrl_keyword_table.sv
// Shadow/active keyword table. Disabled lanes are zeroed when the commit
// loads the active copy, so the outputs come straight from flops.
module keyword_search_ctrl_keyword_table
  import keyword_search_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [WORD_W-1:0]            wdata_i,
  input  logic                         en_wr_i,
  input  logic                         commit_i,
  output logic [NUM_KW-1:0][KW_W-1:0]  kw_o,
  output logic [NUM_KW-1:0]            kw_en_o
);

  logic [NUM_KW-1:0][KW_W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic [NUM_KW-1:0]           sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [1:0]                  kw_idx, word_idx;
  logic [6:0]                  word_lsb;

  assign kw_idx   = addr_i[ADDR_KW_HI:ADDR_KW_LO];
  assign word_idx = addr_i[ADDR_WORD_HI:ADDR_WORD_LO];
  // word 0 is the most significant 32 bits of the keyword
  assign word_lsb = {2'd3 - word_idx, 5'd0};

  always_comb begin
    shadow_d = shadow_q;
    sh_en_d  = sh_en_q;
    active_d = active_q;
    act_en_d = act_en_q;
    if (wr_en_i) begin
      shadow_d[kw_idx][word_lsb +: WORD_W] = wdata_i;
    end else begin
      shadow_d = shadow_q;
    end
    if (en_wr_i) begin
      sh_en_d = wdata_i[NUM_KW-1:0];
    end else begin
      sh_en_d = sh_en_q;
    end
    if (commit_i) begin
      act_en_d = sh_en_q;
      for (int i = 0; i < NUM_KW; i++) begin
        active_d[i] = sh_en_q[i] ? shadow_q[i] : {KW_W{1'b0}};
      end
    end else begin
      active_d = active_q;
      act_en_d = act_en_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      sh_en_q  <= '0;
      active_q <= '0;
      act_en_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      sh_en_q  <= sh_en_d;
      active_q <= active_d;
      act_en_q <= act_en_d;
    end
  end

  assign kw_o    = active_q;
  assign kw_en_o = act_en_q;

endmodule

// File: rtl/keyword_search_ctrl.sv
// Keyword search control: packet-boundary-safe table commits and a
// ready/valid verdict path with saturating counters around the matcher.
module keyword_search_ctrl
  import keyword_search_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr_en,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [WORD_W-1:0] cfg_wdata,
  input  logic              cfg_en_wr,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic              mon_tlast,
  input  logic              match_sig,
  input  logic              no_match_sig,
  output logic              ack,
  output logic [KW_W-1:0]   kw_0,
  output logic [KW_W-1:0]   kw_1,
  output logic [KW_W-1:0]   kw_2,
  output logic [KW_W-1:0]   kw_3,
  output logic [NUM_KW-1:0] kw_enable,
  output logic              verdict_valid,
  output logic              verdict_match,
  input  logic              verdict_ready,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  no_match_count
);

  logic                        beat, commit_fire;
  logic                        in_pkt_q, in_pkt_d, pending_q, pending_d;
  vstate_e                     state_q;
  logic                        valid_q, vmatch_q, ack_q;
  logic [CNT_W-1:0]            match_cnt_q, no_match_cnt_q;
  logic [NUM_KW-1:0][KW_W-1:0] kw_arr;

  assign beat = mon_tvalid & mon_tready;
  // a commit only lands between packets and while no verdict is in flight
  assign commit_fire = pending_q & ~in_pkt_q & ~beat & (state_q == V_IDLE);

  always_comb begin
    in_pkt_d  = in_pkt_q;
    pending_d = pending_q;
    if (beat) begin
      in_pkt_d = ~mon_tlast;
    end else begin
      in_pkt_d = in_pkt_q;
    end
    if (commit_fire) begin
      pending_d = cfg_commit;
    end else begin
      pending_d = pending_q | cfg_commit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_pkt_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      in_pkt_q  <= in_pkt_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= V_IDLE;
      valid_q        <= 1'b0;
      vmatch_q       <= 1'b0;
      ack_q          <= 1'b0;
      match_cnt_q    <= {CNT_W{1'b0}};
      no_match_cnt_q <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        V_IDLE: begin
          ack_q <= 1'b0;
          if (match_sig) begin
            vmatch_q <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= V_HOLD;
          end else if (no_match_sig) begin
            vmatch_q <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= V_HOLD;
          end
        end
        V_HOLD: begin
          if (verdict_ready) begin
            valid_q <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= V_ACK;
            if (vmatch_q) begin
              match_cnt_q <= sat_inc(match_cnt_q);
            end else begin
              no_match_cnt_q <= sat_inc(no_match_cnt_q);
            end
          end
        end
        V_ACK: begin
          ack_q   <= 1'b0;
          state_q <= V_DRAIN;
        end
        V_DRAIN: begin
          if (!match_sig && !no_match_sig) begin
            state_q <= V_IDLE;
          end
        end
        default: begin
          state_q <= V_IDLE;
          valid_q <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  keyword_search_ctrl_keyword_table u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (cfg_wr_en),
    .addr_i   (cfg_addr),
    .wdata_i  (cfg_wdata),
    .en_wr_i  (cfg_en_wr),
    .commit_i (commit_fire),
    .kw_o     (kw_arr),
    .kw_en_o  (kw_enable)
  );

  assign kw_0           = kw_arr[0];
  assign kw_1           = kw_arr[1];
  assign kw_2           = kw_arr[2];
  assign kw_3           = kw_arr[3];
  assign cfg_busy       = pending_q;
  assign ack            = ack_q;
  assign verdict_valid  = valid_q;
  assign verdict_match  = vmatch_q;
  assign match_count    = match_cnt_q;
  assign no_match_count = no_match_cnt_q;

endmodule
